// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stall/flush/forwarding plus syscall drain FSM
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             branch_d,
    input  logic             syscall_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       write_reg_e,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic [4:0]       write_reg_m,
    input  logic             reg_write_m,
    input  logic             mem_to_reg_m,
    input  logic [4:0]       write_reg_w,
    input  logic             reg_write_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             syscall_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] syscall_cnt
);

    typedef enum logic [1:0] {IDLE, DRAIN, RELEASE} state_t;

    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       lwstall, brstall, sysstall, stall;

    // Register 0 is hardwired, so it never counts as a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (reg_write_m && reg_match(write_reg_m, rs_e))      forward_a_e = 2'b10;
        else if (reg_write_w && reg_match(write_reg_w, rs_e)) forward_a_e = 2'b01;
        if (reg_write_m && reg_match(write_reg_m, rt_e))      forward_b_e = 2'b10;
        else if (reg_write_w && reg_match(write_reg_w, rt_e)) forward_b_e = 2'b01;
    end

    assign forward_a_d = reg_write_m && reg_match(write_reg_m, rs_d);
    assign forward_b_d = reg_write_m && reg_match(write_reg_m, rt_d);

    assign lwstall = mem_to_reg_e && (reg_match(rt_e, rs_d) || reg_match(rt_e, rt_d));
    assign brstall = branch_d &&
                     ((reg_write_e  && (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d))) ||
                      (mem_to_reg_m && (reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d))));

    // The detecting IDLE cycle is the first stall cycle, so DRAIN lasts DRAIN_CYCLES-1 cycles.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sysstall = 1'b0;
        case (state)
            IDLE: begin
                if (syscall_d) begin
                    sysstall = 1'b1;
                    if (DRAIN_CYCLES <= 1) begin
                        state_n = RELEASE;
                    end else begin
                        state_n = DRAIN;
                        cnt_n   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                sysstall = 1'b1;
                cnt_n    = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                if (cnt <= 4'd1) state_n = RELEASE;
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign stall        = lwstall | brstall | sysstall;
    assign stall_f      = stall;
    assign stall_d      = stall;
    assign flush_e      = stall;
    assign syscall_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            stall_cnt   <= '0;
            syscall_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (stall && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (state == RELEASE && syscall_cnt != CNT_MAX)
                syscall_cnt <= syscall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int DC    = 3;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic branch_d, syscall_d, reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, reg_write_w;
    logic stall_f, stall_d, flush_e, forward_a_d, forward_b_d, syscall_busy;
    logic [1:0] forward_a_e, forward_b_e;
    logic [CW-1:0] stall_cnt, syscall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .syscall_d(syscall_d),
        .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .syscall_busy(syscall_busy), .stall_cnt(stall_cnt), .syscall_cnt(syscall_cnt)
    );

    always #5 clk = ~clk;

    // Syscall progress is tracked as "stall cycles still owed" plus a pending release flag.
    int drain_left;
    bit rel_pending;
    int m_stall_cnt, m_sys_cnt;
    logic e_stall, e_busy, e_fad, e_fbd;
    logic [1:0] e_fae, e_fbe;

    function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_write_m && dep(write_reg_m, src)) return 2'd2;
        if (reg_write_w && dep(write_reg_w, src)) return 2'd1;
        return 2'd0;
    endfunction

    always_comb begin
        bit lw, br, sys, idle;
        idle  = (drain_left == 0) && !rel_pending;
        lw    = mem_to_reg_e && (dep(rt_e, rs_d) || dep(rt_e, rt_d));
        br    = branch_d && ((reg_write_e && (dep(write_reg_e, rs_d) || dep(write_reg_e, rt_d))) ||
                             (mem_to_reg_m && (dep(write_reg_m, rs_d) || dep(write_reg_m, rt_d))));
        sys   = (idle && syscall_d) || (drain_left > 0);
        e_stall = lw || br || sys;
        e_busy  = !idle;
        e_fae   = fwd_sel(rs_e);
        e_fbe   = fwd_sel(rt_e);
        e_fad   = reg_write_m && dep(write_reg_m, rs_d);
        e_fbd   = reg_write_m && dep(write_reg_m, rt_d);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_left  = 0;
            rel_pending = 0;
            m_stall_cnt = 0;
            m_sys_cnt   = 0;
        end else begin
            if (e_stall && m_stall_cnt < MAXC) m_stall_cnt = m_stall_cnt + 1;
            if (rel_pending) begin
                rel_pending = 0;
                if (m_sys_cnt < MAXC) m_sys_cnt = m_sys_cnt + 1;
            end else if (drain_left > 0) begin
                drain_left = drain_left - 1;
                if (drain_left == 0) rel_pending = 1;
            end else if (syscall_d) begin
                drain_left = DC - 1;
                if (drain_left == 0) rel_pending = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_stall_f", int'(stall_f), int'(e_stall));
        chk("model_stall_d", int'(stall_d), int'(e_stall));
        chk("model_flush_e", int'(flush_e), int'(e_stall));
        chk("model_busy", int'(syscall_busy), int'(e_busy));
        chk("model_fwd_a_e", int'(forward_a_e), int'(e_fae));
        chk("model_fwd_b_e", int'(forward_b_e), int'(e_fbe));
        chk("model_fwd_a_d", int'(forward_a_d), int'(e_fad));
        chk("model_fwd_b_d", int'(forward_b_d), int'(e_fbd));
        chk("model_stall_cnt", int'(stall_cnt), m_stall_cnt);
        chk("model_syscall_cnt", int'(syscall_cnt), m_sys_cnt);
    end

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
        {branch_d, syscall_d, reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, reg_write_w} = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // syscall_d held through the release cycle, dropped afterwards.
    task automatic syscall_seq(input string tag);
        syscall_d = 1'b1;
        for (int i = 0; i <= DC; i++) begin
            @(negedge clk);
            chk({tag, "_stall"}, int'(stall_d), (i < DC) ? 1 : 0);
            chk({tag, "_busy"}, int'(syscall_busy), (i > 0) ? 1 : 0);
            next_cycle();
            if (i == DC) syscall_d = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_idle"}, int'(syscall_busy), 0);
        chk({tag, "_syscnt"}, int'(syscall_cnt), 1);
        chk({tag, "_stallcnt"}, int'(stall_cnt), DC);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_syscall_cnt", int'(syscall_cnt), 0);
        chk("rst_busy", int'(syscall_busy), 0);
        chk("rst_stall_f", int'(stall_f), 0);
        rst_n = 1'b1;

        next_cycle();
        mem_to_reg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
        @(negedge clk);
        chk("lw_stall_f", int'(stall_f), 1);
        chk("lw_flush_e", int'(flush_e), 1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("lw_stall_cnt", int'(stall_cnt), 1);
        chk("lw_released", int'(stall_d), 0);

        next_cycle();
        reg_write_m = 1'b1; write_reg_m = 5'd9; reg_write_w = 1'b1; write_reg_w = 5'd9; rs_e = 5'd9;
        @(negedge clk);
        chk("fwd_m_prio", int'(forward_a_e), 2);
        next_cycle();
        write_reg_m = 5'd0; rs_e = 5'd0;
        @(negedge clk);
        chk("fwd_r0", int'(forward_a_e), 0);
        next_cycle();
        rs_e = 5'd9; reg_write_m = 1'b0;
        @(negedge clk);
        chk("fwd_w", int'(forward_a_e), 1);

        next_cycle();
        clear_inputs();
        branch_d = 1'b1; rs_d = 5'd5; reg_write_e = 1'b1; write_reg_e = 5'd5;
        @(negedge clk);
        chk("br_stall", int'(stall_d), 1);
        next_cycle();
        reg_write_e = 1'b0; write_reg_e = 5'd0; reg_write_m = 1'b1; write_reg_m = 5'd5;
        @(negedge clk);
        chk("br_fwd_a_d", int'(forward_a_d), 1);
        chk("br_no_stall", int'(stall_d), 0);

        next_cycle();
        clear_inputs();
        pulse_reset();
        syscall_seq("sys");

        next_cycle();
        syscall_d = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("mid_drain_busy", int'(syscall_busy), 1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(syscall_busy), 0);
        chk("async_stall_cnt", int'(stall_cnt), 0);
        #1;
        rst_n = 1'b1;
        syscall_seq("restart");

        next_cycle();
        pulse_reset();
        mem_to_reg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
        repeat ((1 << CW) + 5) next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("sat_stall_cnt", int'(stall_cnt), MAXC);

        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rs_d         = 5'($urandom_range(0, 3));
            rt_d         = 5'($urandom_range(0, 3));
            rs_e         = 5'($urandom_range(0, 3));
            rt_e         = 5'($urandom_range(0, 3));
            write_reg_e  = 5'($urandom_range(0, 3));
            write_reg_m  = 5'($urandom_range(0, 3));
            write_reg_w  = 5'($urandom_range(0, 3));
            branch_d     = ($urandom_range(0, 3) == 0);
            syscall_d    = ($urandom_range(0, 7) == 0);
            reg_write_e  = $urandom_range(0, 1) == 1;
            mem_to_reg_e = ($urandom_range(0, 3) == 0);
            reg_write_m  = $urandom_range(0, 1) == 1;
            mem_to_reg_m = ($urandom_range(0, 3) == 0);
            reg_write_w  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 40) == 0) begin
                #1;
                pulse_reset();
            end
        end

        next_cycle();
        clear_inputs();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
